seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Six-digit multiplexed seven-segment scan controller. It time-shares one segment bus across six common-anode digits, replacing the PLL-derived scan clock with a prescaler tick on `sys_clk`. It holds a double-buffered frame (hex nibbles, decimal points, digit enables) loaded through a valid/ready handshake and applied only at frame boundaries. It inserts a blanking guard at every digit switch to suppress ghosting.

## Interface
- `TICK_DIV`, default 50000: `sys_clk` cycles per digit slot (50 MHz gives a 1 kHz digit rate); legal range 4..2^20.
- `GUARD`, default 2: `sys_clk` cycles per slot during which all digits are blanked; legal range 1..TICK_DIV-2.

Ports:
- `sys_clk`  in  1  sole clock.
- `sys_rst`  in  1  reset, asynchronous, active-low.
- `data_in`  in  24  digit i hex value in `[4i+3:4i]`; digit 0 drives `sel[0]`.
- `dp_in`  in  6  decimal point per digit, 1 = lit.
- `en_in`  in  6  digit enable per digit, 1 = displayed.
- `load_valid`  in  1  new frame offered on `data_in`/`dp_in`/`en_in`.
- `load_ready`  out  1  pending buffer empty; equals ~pending_full.
- `sel`  out  6  digit select, active-low, at most one bit low.
- `seg`  out  8  segments, active-low, `{dp,g,f,e,d,c,b,a}`.
- `frame_done`  out  1  one-cycle pulse when the scan wraps to digit 0.

## Operation
- Prescaler `pcnt` counts 0..TICK_DIV-1 and wraps. A tick occurs in the cycle where `pcnt`==TICK_DIV-1.
- Digit index `idx` (3 bits) takes values 0..5. On a tick it advances: 5 wraps to 0, and values 6/7 are unreachable.
- Load handshake:
  - Transfer occurs when `load_valid`&&`load_ready`. On transfer, capture the inputs into the pending buffer and set pending_full.
  - `load_valid` may be held; with `load_ready` low, inputs are ignored.
- Frame boundary: the tick on which `idx` wraps 5->0.
  - If pending_full, copy the pending buffer to the shadow buffer and clear pending_full in the same edge.
  - A load accepted in the boundary cycle (pending was empty) lands in pending and is applied at the next boundary.
- Segment decode, registered every cycle from `shadow[idx]`. Active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - `seg[7]` = ~`dp_shadow[idx]`.
- Select: during the guard window `sel`=6'b111111. Otherwise `sel` = ~(1<<`idx`) if `en_shadow[idx]`, else 6'b111111.
- Reset (async assert, any time including mid-slot or mid-handshake):
  - Outputs: `sel`=6'b111111, `seg`=8'hFF, `frame_done`=0.
  - State: `pcnt`=0, `idx`=0, guard counter=0, shadow data/dp/en=0 (display dark), pending_full=0.
  - `load_ready`=1, combinational from pending_full, so it is 1 during reset.
  - Deassertion is synchronised externally. The first tick is TICK_DIV cycles after release.

## Timing
- Tick at cycle T. At T+1:
  - `idx` holds the new value.
  - The guard counter is loaded with GUARD and `sel`=6'b111111.
  - The shadow is updated if T was a boundary.
  - `frame_done`=1 if T was a boundary.
- `seg` reflects the new `idx` and shadow at T+2.
- `sel` asserts the new digit at T+1+GUARD and holds until the next tick's T+1.
- The guard counter decrements once per cycle, from GUARD at T+1 to 0.
- Lit time per slot is TICK_DIV-GUARD cycles. Frame period is 6*TICK_DIV cycles.
- Handshake latency:
  - `load_ready` falls the cycle after acceptance.
  - It rises the cycle after the boundary edge that drains pending.
  - Maximum latency from acceptance to display is 6*TICK_DIV+2 cycles.

## Test plan
- Reset values: with TICK_DIV=8 and GUARD=2, hold `sys_rst`=0, then release. Required: `sel`=111111, `seg`=FF, `load_ready`=1, `frame_done`=0. No `sel` activity occurs, because all shadow enables are 0.
- Scan order and guard: load `data_in`=24'h543210 with `en_in`=6'h3F and `dp_in`=0. After the first boundary, `sel` cycles 111110, 111101, ... 011111 with period 8. Each slot shows 2 cycles of 111111. `seg` equals the decode of 0..5 (digit 0 shows C0). `frame_done` pulses every 48 cycles.
- Boundary-only update: mid-frame, load 24'hFEDCBA with `dp_in`=6'h01. Required: the remaining digits of the current frame are unchanged. The next frame starts with digit 0 showing `seg`=8'h08 (A with dp lit).
- Backpressure: while pending_full, hold `load_valid`=1 with a different value. Required: `load_ready`=0 until the boundary, then 1 for one cycle. The second value is accepted and appears one frame later.
- Digit disable: `en_in`=6'b101010. Required: `sel` is never low on bits 0, 2 or 4. The slot timing of digits 1, 3 and 5 is unchanged.
- Mid-slot reset: assert `sys_rst` during an active slot. Required: the same cycle asynchronously forces `sel`=111111 and `seg`=FF. After release, the display stays dark until a new load crosses a boundary.

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// Frame-load channel of the seven-segment scan controller: one frame of
// hex nibbles, decimal points and digit enables offered with valid/ready.
interface seg_scan_ctrl_if;
    logic [23:0] data_in;
    logic [5:0]  dp_in;
    logic [5:0]  en_in;
    logic        load_valid;
    logic        load_ready;

    modport master (output data_in, dp_in, en_in, load_valid, input load_ready);
    modport slave  (input data_in, dp_in, en_in, load_valid, output load_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Six-digit multiplexed seven-segment scan controller (common anode).
// A prescaler on sys_clk paces the digit slots; a double-buffered frame is
// loaded over the handshake and only swapped in at the 5->0 wrap, and every
// digit switch opens with a short all-blank guard window against ghosting.
module seg_scan_ctrl #(
    parameter int TICK_DIV = 50000,
    parameter int GUARD    = 2
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    seg_scan_ctrl_if.slave ld,
    output logic [5:0]     sel,
    output logic [7:0]     seg,
    output logic           frame_done
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int GW = $clog2(GUARD + 1);

    logic [PW-1:0] pcnt;
    logic [2:0]    idx;
    logic [GW-1:0] gcnt;
    logic          pend_full;
    logic [23:0]   pend_data, shd_data;
    logic [5:0]    pend_dp, pend_en, shd_dp, shd_en;
    logic          tick, boundary, xfer;
    logic [3:0]    cur_nib;

    // Active-low gfedcba pattern for one hex nibble.
    function automatic logic [6:0] dec7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Slot tick, frame boundary and handshake transfer strobes.
    always_comb begin
        tick     = (pcnt == PW'(TICK_DIV - 1));
        boundary = tick && (idx == 3'd5);
        xfer     = ld.load_valid && !pend_full;
        cur_nib  = shd_data[{idx, 2'b00} +: 4];
    end

    assign ld.load_ready = !pend_full;

    // Prescaler and digit index; idx wraps 5 -> 0 so 6/7 never occur.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            pcnt <= '0;
            idx  <= 3'd0;
        end else if (tick) begin
            pcnt <= '0;
            idx  <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    // Guard counter: reloaded on every tick, then counts down to zero.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst)
            gcnt <= '0;
        else if (tick)
            gcnt <= GW'(GUARD);
        else if (gcnt != '0)
            gcnt <= gcnt - GW'(1);
    end

    // Pending/shadow double buffer; drain and accept can never coincide
    // because acceptance needs the pending slot empty.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            pend_full <= 1'b0;
            pend_data <= '0;
            pend_dp   <= '0;
            pend_en   <= '0;
            shd_data  <= '0;
            shd_dp    <= '0;
            shd_en    <= '0;
        end else if (boundary && pend_full) begin
            shd_data  <= pend_data;
            shd_dp    <= pend_dp;
            shd_en    <= pend_en;
            pend_full <= 1'b0;
        end else if (xfer) begin
            pend_data <= ld.data_in;
            pend_dp   <= ld.dp_in;
            pend_en   <= ld.en_in;
            pend_full <= 1'b1;
        end
    end

    // Frame-wrap pulse, one cycle after the boundary tick.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst)
            frame_done <= 1'b0;
        else
            frame_done <= boundary;
    end

    // Registered segment decode of the currently scanned digit.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst)
            seg <= 8'hFF;
        else
            seg <= {~shd_dp[idx], dec7(cur_nib)};
    end

    // Digit select: blank during the guard window or for disabled digits.
    // Reset clears shd_en, so sel goes dark asynchronously with reset.
    always_comb begin
        sel = 6'b111111;
        if (gcnt == '0 && shd_en[idx])
            sel = ~(6'b000001 << idx);
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with TICK_DIV=8, GUARD=2.
module tb_seg_scan_ctrl;
    localparam int TD = 8;
    localparam int GD = 2;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic [5:0] sel;
    logic [7:0] seg;
    logic       frame_done;
    int         total = 0;
    int         bad   = 0;

    seg_scan_ctrl_if lb();

    seg_scan_ctrl #(.TICK_DIV(TD), .GUARD(GD)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .ld         (lb),
        .sel        (sel),
        .seg        (seg),
        .frame_done (frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Segment patterns from the datasheet table, active-low gfedcba.
    function automatic logic [6:0] seg_ref(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[n];
    endfunction

    // Wait for a frame wrap, then check every cycle of the 48-cycle frame.
    // Optional one-shot load at ld_k and a held load starting at hold_k.
    task automatic scan_frame(input logic [23:0] xd, input logic [5:0] xdp, input logic [5:0] xen,
                              input int ld_k, input logic [23:0] ad, input logic [5:0] adp,
                              input logic [5:0] aen, input int hold_k, input logic [23:0] bd,
                              input logic [5:0] bdp, input logic [5:0] ben, input int xwait);
        int         waited;
        bit         held;
        int         d, pos;
        logic [5:0] esel;
        logic [3:0] nib;
        waited = 0;
        held   = lb.load_valid;
        while (1) begin
            @(negedge sys_clk);
            waited++;
            if (frame_done || waited >= 200) break;
        end
        chk("frame_done_pulse", frame_done, 1);
        if (xwait != 0) chk("frame_period", waited, xwait);
        for (int k = 1; k <= 6 * TD; k++) begin
            if (k > 1) @(negedge sys_clk);
            d    = (k - 1) / TD;
            pos  = (k - 1) % TD;
            esel = 6'b111111;
            if (pos >= GD && xen[d]) esel = ~(6'b000001 << d);
            chk("sel", sel, esel);
            if (pos >= 1) begin
                nib = xd[d*4 +: 4];
                chk("seg", seg, {~xdp[d], seg_ref(nib)});
            end
            if (k > 1) chk("frame_done_low", frame_done, 0);
            if (k == 1) chk("ready_after_drain", lb.load_ready, 1);
            if (held && k >= 2) chk("ready_held", lb.load_ready, 0);
            if (ld_k != 0 && k > ld_k) chk("ready_full", lb.load_ready, 0);
            if (k == ld_k) begin
                lb.data_in = ad; lb.dp_in = adp; lb.en_in = aen; lb.load_valid = 1'b1;
            end else if (k == hold_k) begin
                lb.data_in = bd; lb.dp_in = bdp; lb.en_in = ben; lb.load_valid = 1'b1;
            end else if (ld_k != 0 && k == ld_k + 1) begin
                lb.load_valid = 1'b0;
            end else if (held && k == 2) begin
                lb.load_valid = 1'b0;
            end
        end
    endtask

    initial begin
        int lit;
        lb.load_valid = 1'b0;
        lb.data_in    = '0;
        lb.dp_in      = '0;
        lb.en_in      = '0;
        sys_rst       = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("rst_sel", sel, 6'h3F);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_ready", lb.load_ready, 1);
        chk("rst_frame_done", frame_done, 0);
        sys_rst = 1'b1;

        lit = 0;
        repeat (20) begin
            @(negedge sys_clk);
            if (sel != 6'h3F) lit++;
        end
        chk("dark_after_reset", lit, 0);

        lb.data_in = 24'h543210; lb.dp_in = 6'h00; lb.en_in = 6'h3F; lb.load_valid = 1'b1;
        @(negedge sys_clk);
        chk("ready_falls", lb.load_ready, 0);
        lb.load_valid = 1'b0;

        // Frame A: 0..5 scanned; mid-frame load of A..F must wait.
        scan_frame(24'h543210, 6'h00, 6'h3F, 20, 24'hFEDCBA, 6'h01, 6'h3F,
                   0, 24'h0, 6'h0, 6'h0, 0);
        // Frame B: A..F with digit 0 dp; one load accepted, a second held off.
        scan_frame(24'hFEDCBA, 6'h01, 6'h3F, 10, 24'h0789AB, 6'h10, 6'b101010,
                   12, 24'h111111, 6'h00, 6'h3F, 1);
        // Frame C: only odd digits enabled; held load accepted on entry.
        scan_frame(24'h0789AB, 6'h10, 6'b101010, 0, 24'h0, 6'h0, 6'h0,
                   0, 24'h0, 6'h0, 6'h0, 1);
        // Frame D: the held value shows one frame later.
        scan_frame(24'h111111, 6'h00, 6'h3F, 0, 24'h0, 6'h0, 6'h0,
                   0, 24'h0, 6'h0, 6'h0, 1);

        // Mid-slot reset while digit 0 of the next frame is lit.
        repeat (4) @(negedge sys_clk);
        chk("pre_reset_sel", sel, 6'h3E);
        chk("pre_reset_seg", seg, 8'hF9);
        #2 sys_rst = 1'b0;
        #1;
        chk("async_rst_sel", sel, 6'h3F);
        chk("async_rst_seg", seg, 8'hFF);
        chk("async_rst_ready", lb.load_ready, 1);
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b1;
        lit = 0;
        repeat (120) begin
            @(negedge sys_clk);
            if (sel != 6'h3F) lit++;
        end
        chk("dark_after_mid_reset", lit, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
